shift_add_multiplier: RTL and testbench

//   Sequential unsigned shift-and-add multiplier. Produces a 2N-bit product for
//   the downstream N-bit pipeline register pair (low/high halves).

---
 rtl/lab_pkg.sv | 18 +
 rtl/shift_add_multiplier_datapath.sv | 46 ++++
 rtl/shift_add_multiplier.sv | 90 +++++++++
 tb/tb_shift_add_multiplier.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/lab_pkg.sv
// Shared definitions for the shift-and-add multiplier.
//   state_t : FSM state encodings (IDLE / RUN / DONE)
//   cnt_w() : width of the iteration counter for an N-bit operand
package lab_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Counter must hold 0..N-1. Kept at least 1 bit wide so a 1-bit build still
  // has a real register.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/shift_add_multiplier_datapath.sv
// mult_datapath: accumulator, shifting multiplicand and shifting multiplier.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   load              capture a (zero-extended) / b, clear the accumulator
//   step              one add-and-shift iteration
//   a, b              N-bit operands
//   acc_next          accumulator value after the current step
//   mplier_zero_next  multiplier is zero once the current step has shifted it
module mult_datapath #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load,
  input  logic           step,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [2*N-1:0] acc_next,
  output logic           mplier_zero_next
);

  logic [2*N-1:0] acc;
  logic [2*N-1:0] mcand;
  logic [N-1:0]   mplier;

  // Partial sums never exceed (2^N-1)^2, so the 2N-bit add cannot carry out.
  assign acc_next         = mplier[0] ? acc + mcand : acc;
  assign mplier_zero_next = (mplier >> 1) == '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (load) begin
      acc    <= '0;
      mcand  <= {{N{1'b0}}, a};
      mplier <= b;
    end else if (step) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

endmodule

// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier: sequential unsigned multiplier, one add-and-shift per
// clock, start/busy/done handshake, registered 2N-bit product.
// Ports:
//   clk, rst_n  clock, async active-low reset
//   start       request, sampled only in IDLE
//   a, b        operands, captured on the accepting edge
//   busy        high while iterating
//   done        one-cycle pulse when a new product is available
//   product     result, held until the next completion
// Build option: MULT_EARLY_EXIT_EN -- leave RUN as soon as the remaining
// multiplier bits are all zero (product unchanged, latency shortened).
module shift_add_multiplier
  import lab_pkg::*;
#(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);

  localparam int CW = cnt_w(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);
`ifdef MULT_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  state_t         state, state_d;
  logic [CW-1:0]  count;
  logic           load, step, run_exit;
  logic [2*N-1:0] acc_next;
  logic           mplier_zero_next;

  mult_datapath #(.N(N)) u_dp (
    .clk              (clk),
    .rst_n            (rst_n),
    .load             (load),
    .step             (step),
    .a                (a),
    .b                (b),
    .acc_next         (acc_next),
    .mplier_zero_next (mplier_zero_next)
  );

  // Exit on the last counted iteration, or early once no multiplier bits
  // remain to contribute (only when the option is built in).
  assign run_exit = (count == LAST) || (EARLY_EXIT && mplier_zero_next);

  always_comb begin
    state_d = state;
    load    = 1'b0;
    step    = 1'b0;
    case (state)
      ST_IDLE: if (start) begin
        load    = 1'b1;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        step = 1'b1;
        if (run_exit) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      count   <= '0;
      product <= '0;
    end else begin
      state <= state_d;
      if (load)      count <= '0;
      else if (step) count <= count + 1'b1;
      if (step && run_exit) product <= acc_next;
    end
  end

  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier: directed cases plus a random
// sweep, compared against a*b and a latency model derived from b.
module tb_shift_add_multiplier;
  localparam int N = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start;
  logic [N-1:0]   a, b;
  logic           busy, done;
  logic [2*N-1:0] product;

  int checks = 0;
  int errors = 0;

  shift_add_multiplier #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .product(product)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Edges from acceptance to the DONE transition.
  function automatic int exp_lat(input logic [N-1:0] mb);
`ifdef MULT_EARLY_EXIT_EN
    int msb = 0;
    for (int i = 0; i < N; i++) if (mb[i]) msb = i;
    return msb + 1;
`else
    return N;
`endif
  endfunction

  // Called at a negedge with the DUT idle; returns at a negedge, idle again.
  task automatic run_op(input logic [N-1:0] xa, input logic [N-1:0] xb, input string tag);
    logic [2*N-1:0] prev, exp_p;
    int cyc, nbusy;
    bit ok;
    prev  = product;
    exp_p = (2*N)'(xa) * (2*N)'(xb);
    start = 1'b1; a = xa; b = xb;
    @(posedge clk); #1;
    start = 1'b0; a = N'($urandom); b = N'($urandom);
    cyc = 0; nbusy = 0; ok = 0;
    while (cyc < 40) begin
      @(negedge clk); cyc++;
      if (done) begin ok = 1; break; end
      if (busy) nbusy++;
      if (product !== prev) chk({tag, "_hold_run"}, product, prev);
    end
    chk({tag, "_timeout"}, ok, 1);
    chk({tag, "_busy_cycles"}, nbusy, exp_lat(xb));
    chk({tag, "_done_cycle"}, cyc, exp_lat(xb) + 1);
    chk({tag, "_product"}, product, exp_p);
    @(negedge clk);
    chk({tag, "_done_pulse"}, {busy, done}, 2'b00);
    chk({tag, "_hold_after"}, product, exp_p);
  endtask

  initial begin
    int cyc, ndone;
    bit ok;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    #1;
    chk("rst_async", {busy, done, product}, '0);
    #22 rst_n = 1'b1;
    // 1: idle after reset
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle", {busy, done, product}, '0);
    end

    // 2/3: directed values
    run_op(8'd13, 8'd11, "13x11");
    chk("13x11_const", product, 16'h008F);
    run_op(8'd255, 8'd255, "max");
    chk("max_const", product, 16'hFE01);
    run_op(8'd0, 8'd200, "a0");
    run_op(8'd77, 8'd0, "b0");
    run_op(8'd100, 8'd3, "100x3");
    chk("100x3_const", product, 16'h012C);
    run_op(8'd9, 8'd1, "b1");
    run_op(8'd1, 8'd128, "b128");

    // 4: start held high, operands churning
    start = 1'b1; a = 8'd20; b = 8'd30;
    @(posedge clk); #1;
    ndone = 0;
    for (int c = 1; c <= exp_lat(8'd30) + 1; c++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        chk("hold_start_product", product, 16'd600);
      end
      a = N'($urandom); b = N'($urandom);
    end
    chk("hold_start_one_done", ndone, 1);
    a = 8'd5; b = 8'd6;
    @(negedge clk);
    chk("hold_start_idle_gap", {busy, done}, 2'b00);
    @(posedge clk); #1;
    start = 1'b0; a = 8'd99; b = 8'd99;
    @(negedge clk);
    chk("hold_start_reaccept", busy, 1);
    ok = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done) begin ok = 1; break; end
    end
    chk("hold_start_second_done", ok, 1);
    chk("hold_start_second_product", product, 16'd30);
    @(negedge clk);

    // 5: reset during RUN
    start = 1'b1; a = 8'd7; b = 8'd9;
    @(posedge clk); #1; start = 1'b0;
    for (int c = 0; c < 4; c++) @(negedge clk);
    chk("abort_busy_before", busy, 1);
    rst_n = 1'b0; #1;
    chk("abort_cleared", {busy, done, product}, '0);
    @(negedge clk); rst_n = 1'b1;
    ndone = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    chk("abort_no_done", ndone, 0);
    chk("abort_product", product, 16'h0000);
    run_op(8'd7, 8'd9, "7x9");
    chk("7x9_const", product, 16'h003F);

    // 6: random sweep
    for (int i = 0; i < 1000; i++)
      run_op(N'($urandom), N'($urandom), "rand");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
